// File: rtl/sensor_pkg.sv
// Shared constants for the sensor conditioning stage: sensor bit positions,
// channel count, default debounce length and the tank level plausibility rule.
package sensor_pkg;

    localparam int IDX_HH = 0;
    localparam int IDX_MM = 1;
    localparam int IDX_LL = 2;
    localparam int IDX_UA = 3;
    localparam int IDX_US = 4;
    localparam int IDX_T  = 5;

    localparam int N_SENSORS          = 6;
    localparam int DEB_CYCLES_DEFAULT = 50000;

    // A higher level sensor reporting wet while a lower one is dry is physically impossible.
    function automatic logic level_implausible(input logic hh, input logic mm, input logic ll);
        return (hh & ~mm) | (mm & ~ll) | (hh & ~ll);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One conditioning channel: two-flop synchroniser, consecutive-cycle debounce
// counter, stable level register and a one-cycle change pulse.
module debounce_bit
    import sensor_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic change
);

    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Any cycle where the synced value agrees with the stable level restarts the count,
    // so only an uninterrupted run of DEB_CYCLES disagreeing cycles is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
            change <= 1'b0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            change <= 1'b0;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= s2;
                cnt    <= '0;
                change <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sensor_conditioner.sv
// Input conditioning for the irrigation controller: debounced sensor levels,
// change pulses, agro button pulse. Optional level check: SENSOR_COND_LEVEL_CHECK_EN.
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int N_IN       = N_SENSORS,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_IN-1:0] raw_in,
    input  logic            agro_raw,
    output logic [N_IN-1:0] stable_out,
    output logic [N_IN-1:0] changed,
    output logic            agro_pulse,
    output logic            level_fault
);

    // The agro button rides along as the top channel so it gets identical conditioning.
    logic [N_IN:0] ch_raw;
    logic [N_IN:0] ch_stable;
    logic [N_IN:0] ch_change;

    assign ch_raw = {agro_raw, raw_in};

    for (genvar i = 0; i <= N_IN; i++) begin : g_chan
        debounce_bit #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (ch_raw[i]),
            .stable(ch_stable[i]),
            .change(ch_change[i])
        );
    end

    assign stable_out = ch_stable[N_IN-1:0];
    assign changed    = ch_change[N_IN-1:0];
    assign agro_pulse = ch_change[N_IN] & ch_stable[N_IN];

`ifdef SENSOR_COND_LEVEL_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            level_fault <= 1'b0;
        end else begin
            level_fault <= level_implausible(stable_out[IDX_HH], stable_out[IDX_MM], stable_out[IDX_LL]);
        end
    end
`else
    assign level_fault = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner with DEB_CYCLES=4: directed vector
// table for the corner cases, then randomized stimulus against a reference model.
module tb_sensor_conditioner;

    localparam int N   = 6;
    localparam int DEB = 4;

`ifdef SENSOR_COND_LEVEL_CHECK_EN
    localparam bit LC_EN = 1'b1;
`else
    localparam bit LC_EN = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [N-1:0] raw_in;
    logic         agro_raw;
    logic [N-1:0] stable_out;
    logic [N-1:0] changed;
    logic         agro_pulse;
    logic         level_fault;

    int checks = 0;
    int errors = 0;

    sensor_conditioner #(
        .N_IN      (N),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .agro_raw   (agro_raw),
        .stable_out (stable_out),
        .changed    (changed),
        .agro_pulse (agro_pulse),
        .level_fault(level_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit [N-1:0] raw;
        bit         agro;
        bit [N-1:0] st;
        bit [N-1:0] chg;
        bit         ap;
        bit         lf;
    } vec_t;

    vec_t vecs[$];

    // Reference model: each channel accepts a new level once the pin value seen two
    // clocks ago has disagreed with the accepted level for DEB consecutive clocks.
    bit [N:0] hist[$];
    int       run_len[N+1];
    bit [N:0] m_st;
    bit [N:0] m_chg;
    bit       m_lf;

    function automatic bit levelBad(input bit [N:0] s);
        return (s[0] > s[1]) || (s[1] > s[2]) || (s[0] > s[2]);
    endfunction

    task automatic modelStep();
        if (reset) begin
            hist.delete();
            for (int c = 0; c <= N; c++) run_len[c] = 0;
            m_st  = '0;
            m_chg = '0;
            m_lf  = 1'b0;
        end else begin
            m_lf  = LC_EN && levelBad(m_st);
            m_chg = '0;
            for (int c = 0; c <= N; c++) begin
                bit seen;
                seen = (hist.size() >= 2) ? hist[1][c] : 1'b0;
                if (seen != m_st[c]) begin
                    run_len[c]++;
                    if (run_len[c] == DEB) begin
                        m_st[c]    = seen;
                        m_chg[c]   = 1'b1;
                        run_len[c] = 0;
                    end
                end else begin
                    run_len[c] = 0;
                end
            end
            hist.push_front({agro_raw, raw_in});
            if (hist.size() > 2) void'(hist.pop_back());
        end
    endtask

    task automatic applyStimulus(input bit r, input bit [N-1:0] raw, input bit agro);
        reset    = r;
        raw_in   = raw;
        agro_raw = agro;
        modelStep();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int idx, input bit [N-1:0] est,
                               input bit [N-1:0] echg, input bit eap, input bit elf);
        checks++;
        if (stable_out !== est) begin
            errors++;
            $display("[TB] FAIL %s[%0d] stable_out got %h want %h", name, idx, stable_out, est);
        end
        checks++;
        if (changed !== echg) begin
            errors++;
            $display("[TB] FAIL %s[%0d] changed got %h want %h", name, idx, changed, echg);
        end
        checks++;
        if (agro_pulse !== eap) begin
            errors++;
            $display("[TB] FAIL %s[%0d] agro_pulse got %b want %b", name, idx, agro_pulse, eap);
        end
        checks++;
        if (level_fault !== elf) begin
            errors++;
            $display("[TB] FAIL %s[%0d] level_fault got %b want %b", name, idx, level_fault, elf);
        end
    endtask

    task automatic addRows(input int n, input bit rst, input bit [N-1:0] raw, input bit agro,
                           input bit [N-1:0] st, input bit [N-1:0] chg, input bit ap, input bit lf);
        vec_t v;
        v.rst = rst; v.raw = raw; v.agro = agro;
        v.st  = st;  v.chg = chg; v.ap   = ap;   v.lf = lf;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    bit [N-1:0] cur_raw;
    bit         cur_agro;
    bit         cur_rst;

    initial begin
        reset    = 1'b1;
        raw_in   = '1;
        agro_raw = 1'b0;

        // Reset held with all pins high, then full latency after release.
        addRows(3, 1, 6'h3F, 0, 6'h00, 6'h00, 0, 0);
        addRows(5, 0, 6'h3F, 0, 6'h00, 6'h00, 0, 0);
        addRows(1, 0, 6'h3F, 0, 6'h3F, 6'h3F, 0, 0);
        addRows(1, 0, 6'h3F, 0, 6'h3F, 6'h00, 0, 0);
        // LL glitch of 3 cycles is rejected.
        addRows(1, 1, 6'h00, 0, 6'h00, 6'h00, 0, 0);
        addRows(3, 0, 6'h04, 0, 6'h00, 6'h00, 0, 0);
        addRows(6, 0, 6'h00, 0, 6'h00, 6'h00, 0, 0);
        // Agro held 20 cycles: single pulse on the 6th, nothing on release.
        addRows(5,  0, 6'h00, 1, 6'h00, 6'h00, 0, 0);
        addRows(1,  0, 6'h00, 1, 6'h00, 6'h00, 1, 0);
        addRows(14, 0, 6'h00, 1, 6'h00, 6'h00, 0, 0);
        addRows(8,  0, 6'h00, 0, 6'h00, 6'h00, 0, 0);
        // T rises, reset on the 4th cycle restarts the full latency.
        addRows(3, 0, 6'h20, 0, 6'h00, 6'h00, 0, 0);
        addRows(1, 1, 6'h20, 0, 6'h00, 6'h00, 0, 0);
        addRows(5, 0, 6'h20, 0, 6'h00, 6'h00, 0, 0);
        addRows(1, 0, 6'h20, 0, 6'h20, 6'h20, 0, 0);
        addRows(1, 0, 6'h20, 0, 6'h20, 6'h00, 0, 0);
        // Ua and Us together, then Us drops alone.
        addRows(5, 0, 6'h38, 0, 6'h20, 6'h00, 0, 0);
        addRows(1, 0, 6'h38, 0, 6'h38, 6'h18, 0, 0);
        addRows(2, 0, 6'h38, 0, 6'h38, 6'h00, 0, 0);
        addRows(5, 0, 6'h28, 0, 6'h38, 6'h00, 0, 0);
        addRows(1, 0, 6'h28, 0, 6'h28, 6'h10, 0, 0);
        addRows(1, 0, 6'h28, 0, 6'h28, 6'h00, 0, 0);
        // HH wet over dry MM, then a plausible MM+LL level.
        addRows(1, 1, 6'h00, 0, 6'h00, 6'h00, 0, 0);
        addRows(5, 0, 6'h05, 0, 6'h00, 6'h00, 0, 0);
        addRows(1, 0, 6'h05, 0, 6'h05, 6'h05, 0, 0);
        addRows(1, 0, 6'h05, 0, 6'h05, 6'h00, 0, 1);
        addRows(5, 0, 6'h06, 0, 6'h05, 6'h00, 0, 1);
        addRows(1, 0, 6'h06, 0, 6'h06, 6'h03, 0, 1);
        addRows(1, 0, 6'h06, 0, 6'h06, 6'h00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].raw, vecs[i].agro);
            checkOutput("directed", i, vecs[i].st, vecs[i].chg, vecs[i].ap, LC_EN & vecs[i].lf);
        end

        applyStimulus(1'b1, '0, 1'b0);
        checkOutput("rand_reset", 0, '0, '0, 1'b0, 1'b0);
        cur_raw  = '0;
        cur_agro = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 11) == 0) cur_raw[b] = ~cur_raw[b];
            end
            if ($urandom_range(0, 11) == 0) cur_agro = ~cur_agro;
            cur_rst = ($urandom_range(0, 399) == 0);
            applyStimulus(cur_rst, cur_raw, cur_agro);
            checkOutput("random", i, m_st[N-1:0], m_chg[N-1:0], m_chg[N] & m_st[N], m_lf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
